// File: rtl/aes_job_scheduler_pkg.sv
// Shared types for the AES job scheduler: FSM states, key-size codes and the
// key-size to Nk mapping used by the cipher core.
package aes_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BUSY  = 2'd2,
    S_RESP  = 2'd3
  } sched_state_e;

  localparam logic [1:0] KEY128  = 2'd0;
  localparam logic [1:0] KEY192  = 2'd1;
  localparam logic [1:0] KEY256  = 2'd2;
  localparam logic [1:0] KEY_BAD = 2'd3;

  // Nk in 32-bit words; 0 flags a key size the core cannot run.
  function automatic logic [3:0] keysel_to_nk(input logic [1:0] keysel);
    case (keysel)
      KEY128:  return 4'd4;
      KEY192:  return 4'd6;
      KEY256:  return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/aes_job_scheduler_if.sv
// Job, core and response signals of the AES job scheduler; slave is the
// scheduler's view, master is the requesters + cipher core + consumer side.
interface aes_job_scheduler_if #(
  parameter int DATA_W = 128
) ();

  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_data;
  logic [1:0]        req0_keysel;
  logic              req0_dec;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_data;
  logic [1:0]        req1_keysel;
  logic              req1_dec;

  logic              core_start;
  logic [DATA_W-1:0] core_load;
  logic [1:0]        core_keysel;
  logic              core_dec;
  logic              core_done;
  logic [DATA_W-1:0] core_out;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_id;
  logic              rsp_err;

  modport slave (
    input  req0_valid, req0_data, req0_keysel, req0_dec,
    output req0_ready,
    input  req1_valid, req1_data, req1_keysel, req1_dec,
    output req1_ready,
    output core_start, core_load, core_keysel, core_dec,
    input  core_done, core_out,
    output rsp_valid, rsp_data, rsp_id, rsp_err,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_data, req0_keysel, req0_dec,
    input  req0_ready,
    output req1_valid, req1_data, req1_keysel, req1_dec,
    input  req1_ready,
    input  core_start, core_load, core_keysel, core_dec,
    output core_done, core_out,
    input  rsp_valid, rsp_data, rsp_id, rsp_err,
    output rsp_ready
  );

endinterface

// File: rtl/aes_job_scheduler_arb.sv
// Two-way round-robin grant, purely combinational: a lone requester always
// wins; on a tie the requester that was not served last wins.
module aes_rr_arbiter (
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic last_i,
  output logic gnt_vld_o,
  output logic gnt_id_o
);

  assign gnt_vld_o = valid0_i | valid1_i;
  assign gnt_id_o  = valid1_i & (~valid0_i | ~last_i);

endmodule

// File: rtl/aes_job_scheduler.sv
// Shares one AES core between two requesters: accept -> start at +1, result at +2+L; holds RESP until rsp_ready.
// Optional BUSY watchdog enabled by defining AES_SCHED_TIMEOUT_EN.
module aes_job_scheduler
  import aes_sched_pkg::*;
#(
  parameter int DATA_W  = 128,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  aes_job_scheduler_if.slave   bus,
  output logic                 busy
);

  sched_state_e      state_q, state_d;
  logic              last_q, last_d;
  logic              hist_q, hist_d;
  logic [DATA_W-1:0] load_q, load_d;
  logic [1:0]        keysel_q, keysel_d;
  logic              dec_q, dec_d;
  logic              id_q, id_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              err_q, err_d;
  logic              busy_q;

  logic              last_eff;
  logic              gnt_vld;
  logic              gnt_id;
  logic              accept;
  logic [DATA_W-1:0] sel_data;
  logic [1:0]        sel_keysel;
  logic              sel_dec;
  logic              expire;

  // Until the first job is served neither side counts as "last", so req0 wins the first tie.
  assign last_eff = hist_q ? last_q : 1'b1;

  aes_rr_arbiter u_arb (
    .valid0_i  (bus.req0_valid),
    .valid1_i  (bus.req1_valid),
    .last_i    (last_eff),
    .gnt_vld_o (gnt_vld),
    .gnt_id_o  (gnt_id)
  );

  assign accept         = (state_q == S_IDLE) & gnt_vld;
  assign bus.req0_ready = accept & ~gnt_id;
  assign bus.req1_ready = accept & gnt_id;

  assign sel_data   = gnt_id ? bus.req1_data   : bus.req0_data;
  assign sel_keysel = gnt_id ? bus.req1_keysel : bus.req0_keysel;
  assign sel_dec    = gnt_id ? bus.req1_dec    : bus.req0_dec;

`ifdef AES_SCHED_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_ISSUE) begin
      cnt_d = '0;
    end else if (state_q == S_BUSY) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == CNT_W'(TIMEOUT - 1));
`else
  logic [CNT_W-1:0] unused_timeout_cfg;
  assign unused_timeout_cfg = CNT_W'(TIMEOUT);
  assign expire             = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    hist_d     = hist_q;
    load_d     = load_q;
    keysel_d   = keysel_q;
    dec_d      = dec_q;
    id_d       = id_q;
    rsp_data_d = rsp_data_q;
    err_d      = err_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          load_d   = sel_data;
          keysel_d = sel_keysel;
          dec_d    = sel_dec;
          id_d     = gnt_id;
          // An unsupported key size never reaches the core.
          if (sel_keysel == KEY_BAD) begin
            rsp_data_d = '0;
            err_d      = 1'b1;
            state_d    = S_RESP;
          end else begin
            state_d    = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        state_d = S_BUSY;
      end

      S_BUSY: begin
        // A result arriving on the expiry cycle still wins over the abort.
        if (bus.core_done) begin
          rsp_data_d = bus.core_out;
          err_d      = 1'b0;
          state_d    = S_RESP;
        end else if (expire) begin
          rsp_data_d = '0;
          err_d      = 1'b1;
          state_d    = S_RESP;
        end
      end

      S_RESP: begin
        if (bus.rsp_ready) begin
          last_d  = id_q;
          hist_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      last_q     <= 1'b0;
      hist_q     <= 1'b0;
      load_q     <= '0;
      keysel_q   <= '0;
      dec_q      <= 1'b0;
      id_q       <= 1'b0;
      rsp_data_q <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      hist_q     <= hist_d;
      load_q     <= load_d;
      keysel_q   <= keysel_d;
      dec_q      <= dec_d;
      id_q       <= id_d;
      rsp_data_q <= rsp_data_d;
      err_q      <= err_d;
      busy_q     <= (state_d != S_IDLE);
    end
  end

  assign bus.core_start  = (state_q == S_ISSUE);
  assign bus.core_load   = load_q;
  assign bus.core_keysel = keysel_q;
  assign bus.core_dec    = dec_q;

  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_err   = err_q;

  assign busy = busy_q;

endmodule

// File: tb/tb_aes_job_scheduler.sv
// Randomised bench for aes_job_scheduler: job queues per requester, a fixed-latency
// core model and a scoreboard of expected responses derived from the arbitration rules.
module tb_aes_job_scheduler;
  import aes_sched_pkg::*;

  localparam int DW  = 128;
  localparam int LAT = 10;
  localparam int TMO = 64;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  typedef struct packed {
    logic [127:0] d;
    logic [1:0]   ks;
    logic         dec;
  } job_t;

  typedef struct {
    logic [127:0] d;
    logic         id;
    logic         err;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  always #5 clk = ~clk;

  aes_job_scheduler_if #(.DATA_W(DW)) bus ();

  aes_job_scheduler #(.DATA_W(DW), .TIMEOUT(TMO), .CNT_W(7)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Stand-in cipher: the known AES-128 vector, otherwise a cheap keyed scramble.
  function automatic logic [127:0] core_fn(input logic [127:0] d, input logic [1:0] ks, input logic dec);
    if (d == PT && ks == KEY128 && !dec) return CT;
    return {d[63:0], d[127:64]} ^ {{64{dec}}, 62'h0, ks};
  endfunction

  function automatic job_t rand_job();
    job_t j;
    j.d   = {$urandom, $urandom, $urandom, $urandom};
    j.ks  = 2'($urandom_range(3));
    j.dec = 1'($urandom_range(1));
    return j;
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Core model: done pulses LAT cycles after the start pulse unless muted.
  int           cd;
  int           start_cnt;
  logic         m_done;
  logic [127:0] m_out;
  logic         inj_done;
  bit           mute;

  assign bus.core_done = m_done | inj_done;
  assign bus.core_out  = inj_done ? {4{32'hdeadbeef}} : m_out;

  initial begin
    cd = 0; start_cnt = 0; m_done = 1'b0; m_out = '0;
    forever begin
      @(posedge clk); #1;
      m_done = 1'b0;
      if (!rst_n) begin
        cd = 0;
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0 && !mute) begin
            m_done = 1'b1;
            m_out  = core_fn(bus.core_load, bus.core_keysel, bus.core_dec);
          end
        end
        if (bus.core_start) begin
          start_cnt++;
          cd = LAT;
        end
      end
    end
  end

  job_t q0[$];
  job_t q1[$];
  exp_t expq[$];
  logic grants[$];
  job_t cur;
  bit   m_hist, m_last, inflight;

  task automatic drive_req(input int vpct);
    bus.req0_valid = (q0.size() > 0) && (int'($urandom_range(99)) < vpct);
    bus.req1_valid = (q1.size() > 0) && (int'($urandom_range(99)) < vpct);
    if (q0.size() > 0) begin
      bus.req0_data = q0[0].d; bus.req0_keysel = q0[0].ks; bus.req0_dec = q0[0].dec;
    end
    if (q1.size() > 0) begin
      bus.req1_data = q1[0].d; bus.req1_keysel = q1[0].ks; bus.req1_dec = q1[0].dec;
    end
  endtask

  task automatic run_jobs(input int vpct, input int rpct, input int bp, input int max_cyc);
    int   n = 0;
    int   bp_left = bp;
    int   acc_cyc = 0;
    int   st0 = start_cnt;
    int   exp_st = 0;
    bit   held = 1'b0;
    logic v0, v1, r0, r1, rv, rr, cs, exp_any, exp_win;
    exp_t e;
    job_t j;
    drive_req(vpct);
    bus.rsp_ready = (bp_left > 0) ? 1'b0 : (int'($urandom_range(99)) < rpct);
    while ((q0.size() != 0 || q1.size() != 0 || expq.size() != 0) && n < max_cyc) begin
      @(negedge clk);
      n++;
      v0 = bus.req0_valid; v1 = bus.req1_valid;
      r0 = bus.req0_ready; r1 = bus.req1_ready;
      rv = bus.rsp_valid;  rr = bus.rsp_ready; cs = bus.core_start;
      exp_any = !inflight && (v0 || v1);
      exp_win = (v0 && v1) ? (m_hist ? !m_last : 1'b0) : v1;
      check_val("req0_ready", 128'(r0), 128'(exp_any && !exp_win));
      check_val("req1_ready", 128'(r1), 128'(exp_any && exp_win));
      if ((r0 && v0) || (r1 && v1)) begin
        j = (r1 && v1) ? q1[0] : q0[0];
        e.id = r1 && v1;
        if (j.ks == KEY_BAD) begin
          e.d = '0; e.err = 1'b1; e.lat = 1;
        end else if (mute) begin
          e.d = '0; e.err = 1'b1; e.lat = 2 + TMO;
        end else begin
          e.d = core_fn(j.d, j.ks, j.dec); e.err = 1'b0; e.lat = LAT + 2;
        end
        if (j.ks != KEY_BAD) exp_st++;
        expq.push_back(e);
        grants.push_back(e.id);
        acc_cyc  = cyc;
        inflight = 1'b1;
        cur      = j;
      end
      if (cs) begin
        check_val("core_load", bus.core_load, cur.d);
        check_val("core_keysel", 128'(bus.core_keysel), 128'(cur.ks));
        check_val("core_dec", 128'(bus.core_dec), 128'(cur.dec));
      end
      if (rv) begin
        check_val("start_in_resp", 128'(cs), 128'(0));
        if (expq.size() == 0) begin
          check_val("spurious_rsp", 128'(rv), 128'(0));
        end else begin
          if (!held) check_val("rsp_latency", 128'(cyc - acc_cyc), 128'(expq[0].lat));
          check_val("rsp_data", bus.rsp_data, expq[0].d);
          check_val("rsp_id", 128'(bus.rsp_id), 128'(expq[0].id));
          check_val("rsp_err", 128'(bus.rsp_err), 128'(expq[0].err));
          if (rr) begin
            m_last   = expq[0].id;
            m_hist   = 1'b1;
            inflight = 1'b0;
            void'(expq.pop_front());
          end
        end
      end
      held = rv && !rr;
      @(posedge clk); #1;
      if (r0 && v0) void'(q0.pop_front());
      if (r1 && v1) void'(q1.pop_front());
      if (rv && bp_left > 0) bp_left--;
      drive_req(vpct);
      bus.rsp_ready = (bp_left > 0) ? 1'b0 : (int'($urandom_range(99)) < rpct);
    end
    check_val("jobs_drained", 128'(q0.size() + q1.size() + expq.size()), 128'(0));
    check_val("start_count", 128'(start_cnt - st0), 128'(exp_st));
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic accept_one(input job_t j);
    int n = 0;
    bit got = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_data = j.d; bus.req0_keysel = j.ks; bus.req0_dec = j.dec;
    while (!got && n < 50) begin
      @(negedge clk);
      n++;
      got = bus.req0_ready;
    end
    check_val("accept_one", 128'(got), 128'(1));
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    job_t j;
    bus.req0_valid = 1'b0; bus.req0_data = '0; bus.req0_keysel = '0; bus.req0_dec = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_keysel = '0; bus.req1_dec = 1'b0;
    bus.rsp_ready = 1'b0; inj_done = 1'b0; mute = 1'b0;
    m_hist = 1'b0; m_last = 1'b0; inflight = 1'b0; cur = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_busy", 128'(busy), 128'(0));
    check_val("rst_core_start", 128'(bus.core_start), 128'(0));
    check_val("rst_core_load", bus.core_load, 128'(0));
    check_val("rst_rsp_valid", 128'(bus.rsp_valid), 128'(0));
    check_val("rst_rsp_data", bus.rsp_data, 128'(0));
    check_val("rst_rsp_err", 128'(bus.rsp_err), 128'(0));
    check_val("rst_ready", 128'({bus.req0_ready, bus.req1_ready}), 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single known-vector job on requester 0
    j.d = PT; j.ks = KEY128; j.dec = 1'b0;
    q0.push_back(j);
    run_jobs(100, 100, 0, 100);

    // Invalid key size on requester 1
    j = rand_job(); j.ks = KEY_BAD;
    q1.push_back(j);
    run_jobs(100, 100, 0, 100);

    // Contention: both requesters continuously valid
    grants.delete();
    for (int i = 0; i < 3; i++) begin
      j = rand_job(); if (j.ks == KEY_BAD) j.ks = KEY256; q0.push_back(j);
      j = rand_job(); if (j.ks == KEY_BAD) j.ks = KEY192; q1.push_back(j);
    end
    run_jobs(100, 100, 0, 400);
    check_val("grant_count", 128'(grants.size()), 128'(6));
    for (int i = 0; i < grants.size(); i++) begin
      check_val("grant_order", 128'(grants[i]), 128'(i % 2));
    end

    // Backpressure: response held 20 cycles with the other requester waiting
    j = rand_job(); j.ks = KEY192; q0.push_back(j);
    j = rand_job(); j.ks = KEY256; q1.push_back(j);
    run_jobs(100, 100, 20, 300);

    // Random traffic with valid gaps and random rsp_ready
    for (int i = 0; i < 8; i++) begin
      q0.push_back(rand_job());
      q1.push_back(rand_job());
    end
    run_jobs(60, 60, 0, 3000);

`ifdef AES_SCHED_TIMEOUT_EN
    mute = 1'b1;
    j = rand_job(); j.ks = KEY128; q0.push_back(j);
    run_jobs(100, 100, 0, 400);
    j = rand_job(); j.ks = KEY256;
    accept_one(j);
    repeat (5) @(posedge clk);
`else
    mute = 1'b1;
    j = rand_job(); j.ks = KEY256; j.d[0] = 1'b1;
    accept_one(j);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i % 25 == 24) begin
        check_val("stuck_busy", 128'(busy), 128'(1));
        check_val("stuck_no_rsp", 128'(bus.rsp_valid), 128'(0));
      end
    end
    @(posedge clk);
`endif

    // Asynchronous reset while the core is busy
    #3;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_busy", 128'(busy), 128'(0));
    check_val("mid_rst_core_load", bus.core_load, 128'(0));
    check_val("mid_rst_core_keysel", 128'(bus.core_keysel), 128'(0));
    check_val("mid_rst_core_start", 128'(bus.core_start), 128'(0));
    check_val("mid_rst_rsp_valid", 128'(bus.rsp_valid), 128'(0));
    check_val("mid_rst_rsp_err", 128'(bus.rsp_err), 128'(0));
    m_hist = 1'b0; inflight = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    inj_done = 1'b1;
    @(posedge clk); #1;
    inj_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("late_done_rsp", 128'(bus.rsp_valid), 128'(0));
      check_val("late_done_busy", 128'(busy), 128'(0));
    end
    mute = 1'b0;
    @(posedge clk); #1;
    j = rand_job(); j.ks = KEY128;
    q1.push_back(j);
    run_jobs(100, 100, 0, 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
